player_shot: RTL



---
 rtl/player_shot_pkg.sv | 38 +++
 rtl/player_shot_slot.sv | 51 +++++
 rtl/player_shot.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/player_shot_pkg.sv
// Shared playfield constants, shot defaults and the shot slot record used by
// the player projectile engine.
package params;

  localparam int HRES     = 640;
  localparam int VRES     = 480;
  localparam int PADDLE_H = 16;

  localparam int          MAX_SHOTS     = 4;
  localparam int          SHOT_W        = 4;
  localparam int          SHOT_H        = 12;
  localparam int          SHOT_VEL      = 8;
  localparam int          FIRE_COOLDOWN = 8;
  localparam logic [23:0] SHOT_COLOR    = 24'hFFFF00;

  typedef struct packed {
    logic              valid;
    logic signed [11:0] x;
    logic signed [11:0] y;
  } shot_t;

  // Left edge of a new shot centred on the paddle, kept fully on screen.
  function automatic logic signed [11:0] clamp_x(input logic signed [11:0] center,
                                                 input int w);
    logic signed [11:0] left;
    logic signed [11:0] right_max;
    left      = center - $signed(12'(w / 2));
    right_max = $signed(12'(HRES - w));
    if (left < 12'sd0) begin
      return 12'sd0;
    end else if (left > right_max) begin
      return right_max;
    end else begin
      return left;
    end
  endfunction

endpackage

// File: rtl/player_shot_slot.sv
// One projectile slot: spawn load, per-frame upward move with off-screen
// retirement, hit clearing and pixel coverage.
module shot_slot
  import params::*;
#(
  parameter int SHOT_W   = params::SHOT_W,
  parameter int SHOT_H   = params::SHOT_H,
  parameter int SHOT_VEL = params::SHOT_VEL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic               hit,
  input  logic               spawn,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic signed [11:0] spawn_x,
  input  logic signed [11:0] spawn_y,
  output logic               valid,
  output logic               covers
);

  shot_t              slot;
  logic signed [11:0] next_y;
  logic               in_x;
  logic               in_y;

  assign next_y = slot.y - $signed(12'(SHOT_VEL));
  assign in_x   = (hpos >= slot.x) && (hpos < slot.x + $signed(12'(SHOT_W)));
  assign in_y   = (vpos >= slot.y) && (vpos < slot.y + $signed(12'(SHOT_H)));
  assign covers = slot.valid & in_x & in_y;
  assign valid  = slot.valid;

  // A hit outranks the frame move; spawn only ever targets an empty slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot <= '0;
    end else if (spawn) begin
      slot <= '{valid: 1'b1, x: spawn_x, y: spawn_y};
    end else if (hit && covers) begin
      slot.valid <= 1'b0;
    end else if (fsync && slot.valid) begin
      if (next_y < 12'sd0) begin
        slot.valid <= 1'b0;
      end else begin
        slot.y <= next_y;
      end
    end
  end

endmodule

// File: rtl/player_shot.sv
// Player projectile engine: fire synchronisation, cooldown, slot allocation,
// live count and shot colouring for the compositor.
module player_shot
  import params::*;
#(
  parameter int          MAX_SHOTS     = params::MAX_SHOTS,
  parameter int          SHOT_W        = params::SHOT_W,
  parameter int          SHOT_H        = params::SHOT_H,
  parameter int          SHOT_VEL      = params::SHOT_VEL,
  parameter int          FIRE_COOLDOWN = params::FIRE_COOLDOWN,
  parameter logic [23:0] SHOT_COLOR    = params::SHOT_COLOR
) (
  input  logic               pixel_clk,
  input  logic               rst,
  input  logic               fsync,
  input  logic signed [11:0] hpos,
  input  logic signed [11:0] vpos,
  input  logic               fire,
  input  logic signed [11:0] paddle_center_x,
  input  logic               hit,
  output logic [7:0]         pixel [0:2],
  output logic               active,
  output logic               fired,
  output logic [3:0]         live_count
);

  localparam int CD_W = (FIRE_COOLDOWN > 1) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam logic signed [11:0]    SPAWN_Y = 12'(VRES - PADDLE_H - SHOT_H);
  localparam logic [MAX_SHOTS-1:0]  ONE     = MAX_SHOTS'(1);

  logic [2:0]           sync;
  logic                 sync_d;
  logic [1:0]           fill;
  logic                 armed;
  logic                 fire_rise;
  logic                 fire_req;
  logic [CD_W-1:0]      cooldown;
  logic [MAX_SHOTS-1:0] valid;
  logic [MAX_SHOTS-1:0] covers;
  logic [MAX_SHOTS-1:0] free;
  logic [MAX_SHOTS-1:0] spawn_sel;
  logic                 spawn;
  logic signed [11:0]   spawn_x;

  function automatic logic [3:0] count_live(input logic [MAX_SHOTS-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < MAX_SHOTS; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // An edge only counts once the button has been seen released after reset,
  // so a button held through reset cannot fire on its own.
  assign fire_rise = sync[2] & ~sync_d & armed;
  assign free      = ~valid;
  assign spawn     = fsync & fire_req & (cooldown == '0) & (|free);
  assign spawn_sel = spawn ? (free & (~free + ONE)) : '0;
  assign spawn_x   = clamp_x(paddle_center_x, SHOT_W);

  // Button synchroniser, release arming and the per-frame fire request.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      sync     <= 3'b000;
      sync_d   <= 1'b0;
      fill     <= 2'd0;
      armed    <= 1'b0;
      fire_req <= 1'b0;
    end else begin
      sync   <= {sync[1:0], fire};
      sync_d <= sync[2];
      if (fill != 2'd3) begin
        fill <= fill + 2'd1;
      end
      if (fill == 2'd3 && !sync[2]) begin
        armed <= 1'b1;
      end
      if (fire_rise) begin
        fire_req <= 1'b1;
      end else if (fsync) begin
        fire_req <= 1'b0;
      end
    end
  end

  // Cooldown reload on spawn beats the per-frame decrement.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cooldown <= '0;
      fired    <= 1'b0;
    end else begin
      fired <= spawn;
      if (spawn) begin
        cooldown <= CD_W'(FIRE_COOLDOWN);
      end else if (fsync && cooldown != '0) begin
        cooldown <= cooldown - CD_W'(1);
      end
    end
  end

  // Live count trails the slot state by one cycle.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      live_count <= 4'd0;
    end else begin
      live_count <= count_live(valid);
    end
  end

  for (genvar i = 0; i < MAX_SHOTS; i++) begin : g_slot
    shot_slot #(
      .SHOT_W  (SHOT_W),
      .SHOT_H  (SHOT_H),
      .SHOT_VEL(SHOT_VEL)
    ) u_slot (
      .clk    (pixel_clk),
      .rst    (rst),
      .fsync  (fsync),
      .hit    (hit),
      .spawn  (spawn_sel[i]),
      .hpos   (hpos),
      .vpos   (vpos),
      .spawn_x(spawn_x),
      .spawn_y(SPAWN_Y),
      .valid  (valid[i]),
      .covers (covers[i])
    );
  end

  assign active = |covers;

  // Colour mux: B, G, R in pixel[0..2].
  always_comb begin
    if (active) begin
      pixel[0] = SHOT_COLOR[7:0];
      pixel[1] = SHOT_COLOR[15:8];
      pixel[2] = SHOT_COLOR[23:16];
    end else begin
      pixel[0] = 8'h00;
      pixel[1] = 8'h00;
      pixel[2] = 8'h00;
    end
  end

endmodule
